// File: rtl/cic_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : cic_ctrl_if
//  Brief    : Control/handshake bundle between the CIC decimation controller
//             and its surroundings (enable, comb data in, sample stream out).
//  Revision : 1.0 - initial release
// ============================================================================
interface cic_ctrl_if #(
    parameter int OW = 19
);
    logic          i_enable;
    logic [OW-1:0] i_cic_data;
    logic          i_ready;
    logic          i_clr_overrun;
    logic          o_pdm_clk;
    logic          o_sample_en;
    logic          o_dec_strobe;
    logic [OW-1:0] o_data;
    logic          o_valid;
    logic          o_overrun;
    logic [1:0]    o_state;

    // Controller side: drives the PDM clock, pulses and the sample stream
    modport master (
        input  i_enable, i_cic_data, i_ready, i_clr_overrun,
        output o_pdm_clk, o_sample_en, o_dec_strobe, o_data, o_valid,
        output o_overrun, o_state
    );

    // Environment side: requests operation and consumes samples
    modport slave (
        output i_enable, i_cic_data, i_ready, i_clr_overrun,
        input  o_pdm_clk, o_sample_en, o_dec_strobe, o_data, o_valid,
        input  o_overrun, o_state
    );
endinterface
`default_nettype wire

// File: rtl/cic_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : cic_ctrl
//  Brief    : Timing/control for a PDM CIC decimator: PDM clock generation,
//             integrator/comb advance pulses, warm-up discard, output
//             capture with valid/ready handshake and sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module cic_ctrl #(
    parameter int OW      = 19,
    parameter int R       = 16,
    parameter int N       = 3,
    parameter int PDM_DIV = 4
) (
    input  wire logic  clk,
    input  wire logic  i_reset,
    cic_ctrl_if.master bus
);

    localparam int c_div_w  = $clog2(PDM_DIV);
    localparam int c_dec_w  = $clog2(R);
    localparam int c_warm_w = $clog2(N + 1);

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(PDM_DIV - 1);
    localparam logic [c_div_w-1:0]  c_div_half  = c_div_w'(PDM_DIV / 2);
    localparam logic [c_dec_w-1:0]  c_dec_last  = c_dec_w'(R - 1);
    localparam logic [c_warm_w-1:0] c_warm_last = c_warm_w'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_div_w-1:0]  r_div;
    logic [c_dec_w-1:0]  r_dec;
    logic [c_warm_w-1:0] r_warm;
    logic                r_pdm_clk;
    logic                r_sample_en;
    logic                r_dec_strobe;
    logic                r_cap_pend;   // strobe seen last cycle: capture now
    logic                r_stop_cap;   // that strobe happened in STOP
    logic [OW-1:0]       r_data;
    logic                r_valid;
    logic                r_overrun;

    logic [c_div_w-1:0]  w_div_nxt;
    logic [c_dec_w-1:0]  w_dec_nxt;
    logic                w_sample_nxt;
    logic                w_strobe_nxt;

    // Next-cycle counter values; outputs are registered from these so that
    // each pulse lines up with the counter value of the cycle it appears in
    always_comb begin
        w_div_nxt    = (r_div == c_div_last) ? '0 : r_div + 1'b1;
        w_dec_nxt    = r_dec;
        if (r_sample_en) begin
            w_dec_nxt = (r_dec == c_dec_last) ? '0 : r_dec + 1'b1;
        end
        w_sample_nxt = (w_div_nxt == c_div_last);
        w_strobe_nxt = w_sample_nxt && (w_dec_nxt == c_dec_last);
    end

    // Sequencer: state, counters and registered clock/pulse outputs
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_dec        <= '0;
            r_warm       <= '0;
            r_pdm_clk    <= 1'b0;
            r_sample_en  <= 1'b0;
            r_dec_strobe <= 1'b0;
            r_cap_pend   <= 1'b0;
            r_stop_cap   <= 1'b0;
        end else begin
            r_cap_pend <= 1'b0;
            r_stop_cap <= 1'b0;
            // Free-running PDM timing outside IDLE; IDLE branches override
            r_div        <= w_div_nxt;
            r_dec        <= w_dec_nxt;
            r_pdm_clk    <= (w_div_nxt < c_div_half);
            r_sample_en  <= w_sample_nxt;
            r_dec_strobe <= w_strobe_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_div        <= '0;
                    r_dec        <= '0;
                    r_warm       <= '0;
                    r_sample_en  <= 1'b0;
                    r_dec_strobe <= 1'b0;
                    r_pdm_clk    <= 1'b0;
                    if (bus.i_enable) begin
                        r_state   <= ST_WARMUP;
                        r_pdm_clk <= 1'b1;   // first WARMUP cycle has div 0
                    end
                end
                ST_WARMUP: begin
                    if (!bus.i_enable) begin
                        r_state      <= ST_IDLE;
                        r_div        <= '0;
                        r_dec        <= '0;
                        r_warm       <= '0;
                        r_pdm_clk    <= 1'b0;
                        r_sample_en  <= 1'b0;
                        r_dec_strobe <= 1'b0;
                    end else if (r_dec_strobe) begin
                        // Warm-up outputs are discarded; the N-th one too
                        r_warm <= r_warm + 1'b1;
                        if (r_warm == c_warm_last) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_cap_pend <= r_dec_strobe;
                    if (!bus.i_enable) begin
                        r_state <= ST_STOP;
                    end
                end
                default: begin
                    // STOP: finish the frame in flight, then park in IDLE
                    r_cap_pend <= r_dec_strobe;
                    r_stop_cap <= r_dec_strobe;
                    if (r_stop_cap) begin
                        r_state      <= ST_IDLE;
                        r_div        <= '0;
                        r_dec        <= '0;
                        r_warm       <= '0;
                        r_pdm_clk    <= 1'b0;
                        r_sample_en  <= 1'b0;
                        r_dec_strobe <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Output holding register: capture, handshake transfer, overrun flag
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_cap_pend) begin
                r_data  <= bus.i_cic_data;
                r_valid <= 1'b1;
            end else if (r_valid && bus.i_ready) begin
                r_valid <= 1'b0;
            end
            // A set beats a simultaneous clear
            if (r_cap_pend && r_valid && !bus.i_ready) begin
                r_overrun <= 1'b1;
            end else if (bus.i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.o_pdm_clk    = r_pdm_clk;
    assign bus.o_sample_en  = r_sample_en;
    assign bus.o_dec_strobe = r_dec_strobe;
    assign bus.o_data       = r_data;
    assign bus.o_valid      = r_valid;
    assign bus.o_overrun    = r_overrun;
    assign bus.o_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cic_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cic_ctrl
//  Brief    : Directed, table-driven bench for cic_ctrl with default
//             parameters (OW=19, R=16, N=3, PDM_DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cic_ctrl;

    localparam int OW = 19;

    logic clk = 1'b0;
    logic i_reset;

    cic_ctrl_if #(.OW(OW)) bus ();

    cic_ctrl #(
        .OW      (OW),
        .R       (16),
        .N       (3),
        .PDM_DIV (4)
    ) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            rel;
        logic          en;
        logic          rdy;
        logic [1:0]    st;
        logic          pdm;
        logic          se;
        logic          ds;
        logic          vld;
        logic          dchk;
        logic [OW-1:0] dat;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rel   = 0;   // cycle index relative to the first WARMUP cycle

    // Comb data presented in each cycle is a known function of the cycle
    function automatic logic [OW-1:0] dval(int x);
        return OW'(x * 7 + 1);
    endfunction

    function automatic vec_t mk(int r, logic en, logic rdy, logic [1:0] st,
                                logic pdm, logic se, logic ds, logic vld,
                                logic dchk, logic [OW-1:0] dat);
        vec_t v;
        v.rel = r; v.en = en; v.rdy = rdy; v.st = st; v.pdm = pdm;
        v.se = se; v.ds = ds; v.vld = vld; v.dchk = dchk; v.dat = dat;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
        bus.i_cic_data = dval(rel);
    endtask

    task automatic run_to(int t);
        while (rel < t) tick();
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (rel %0d)", nm, act, exp, rel);
        end
    endtask

    task automatic start_run();
        bus.i_enable = 1'b1;
        rel = -1;
        tick();
    endtask

    initial begin
        logic [63:0] act;
        logic [63:0] exp;
        logic        bad;

        i_reset           = 1'b0;
        bus.i_enable      = 1'b0;
        bus.i_ready       = 1'b1;
        bus.i_clr_overrun = 1'b0;
        bus.i_cic_data    = '0;

        // Run 1: warm-up, first capture, stop sequence (ready held high)
        //            rel  en rdy st   pdm se ds v  dchk data
        tbl.push_back(mk(  0, 1, 1, 2'd1, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(  1, 1, 1, 2'd1, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(  2, 1, 1, 2'd1, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(  3, 1, 1, 2'd1, 0, 1, 0, 0, 0, '0));
        tbl.push_back(mk(  4, 1, 1, 2'd1, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk( 63, 1, 1, 2'd1, 0, 1, 1, 0, 0, '0));
        tbl.push_back(mk( 64, 1, 1, 2'd1, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(127, 1, 1, 2'd1, 0, 1, 1, 0, 0, '0));
        tbl.push_back(mk(191, 1, 1, 2'd1, 0, 1, 1, 0, 0, '0));
        tbl.push_back(mk(192, 1, 1, 2'd2, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(255, 1, 1, 2'd2, 0, 1, 1, 0, 0, '0));
        tbl.push_back(mk(256, 1, 1, 2'd2, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(257, 1, 1, 2'd2, 1, 0, 0, 1, 1, dval(256)));
        tbl.push_back(mk(258, 1, 1, 2'd2, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(300, 0, 1, 2'd2, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(301, 0, 1, 2'd3, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(319, 0, 1, 2'd3, 0, 1, 1, 0, 0, '0));
        tbl.push_back(mk(320, 0, 1, 2'd3, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(321, 0, 1, 2'd0, 0, 0, 0, 1, 1, dval(320)));
        tbl.push_back(mk(322, 0, 1, 2'd0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(330, 0, 1, 2'd0, 0, 0, 0, 0, 0, '0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {bus.o_state, bus.o_pdm_clk, bus.o_sample_en, bus.o_dec_strobe,
             bus.o_valid, bus.o_overrun, bus.o_data}, 64'd0);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        tick();
        tick();
        chk("idle_after_release",
            {bus.o_state, bus.o_pdm_clk, bus.o_sample_en, bus.o_dec_strobe,
             bus.o_valid}, 64'd0);

        start_run();
        foreach (tbl[i]) begin
            run_to(tbl[i].rel);
            act = {bus.o_state, bus.o_pdm_clk, bus.o_sample_en, bus.o_dec_strobe,
                   bus.o_valid, (tbl[i].dchk ? bus.o_data : {OW{1'b0}})};
            exp = {tbl[i].st, tbl[i].pdm, tbl[i].se, tbl[i].ds, tbl[i].vld,
                   (tbl[i].dchk ? tbl[i].dat : {OW{1'b0}})};
            chk($sformatf("vec%0d_rel%0d", i, tbl[i].rel), act, exp);
            bus.i_enable = tbl[i].en;
            bus.i_ready  = tbl[i].rdy;
        end

        // Run 2: enable dropped during warm-up -> immediate IDLE, no output
        start_run();
        run_to(100);
        chk("warm_drop_state_before", bus.o_state, 64'd1);
        bus.i_enable = 1'b0;
        tick();
        chk("warm_drop_idle", {bus.o_state, bus.o_pdm_clk}, 64'd0);
        bad = 1'b0;
        while (rel < 400) begin
            tick();
            if (bus.o_valid || bus.o_sample_en || bus.o_dec_strobe ||
                bus.o_pdm_clk || bus.o_state != 2'd0) bad = 1'b1;
        end
        chk("warm_drop_quiet", bad, 64'd0);

        // Run 3: full warm-up again, then overrun / coincident-transfer cases
        start_run();
        run_to(63);
        chk("rw_strobe1", {bus.o_state, bus.o_dec_strobe}, {2'd1, 1'b1});
        run_to(127);
        chk("rw_strobe2", {bus.o_state, bus.o_dec_strobe}, {2'd1, 1'b1});
        run_to(191);
        chk("rw_strobe3", {bus.o_state, bus.o_dec_strobe}, {2'd1, 1'b1});
        run_to(192);
        chk("rw_run", bus.o_state, 64'd2);
        run_to(256);
        chk("rw_no_valid_yet", bus.o_valid, 64'd0);
        run_to(257);
        chk("rw_first_valid", {bus.o_valid, bus.o_data}, {1'b1, dval(256)});
        run_to(260);
        bus.i_ready = 1'b0;
        run_to(321);
        chk("ovr_first", {bus.o_valid, bus.o_overrun, bus.o_data},
            {1'b1, 1'b0, dval(320)});
        run_to(384);
        chk("ovr_retained", {bus.o_valid, bus.o_overrun, bus.o_data},
            {1'b1, 1'b0, dval(320)});
        run_to(385);
        chk("ovr_overwrite", {bus.o_valid, bus.o_overrun, bus.o_data},
            {1'b1, 1'b1, dval(384)});
        run_to(400);
        bus.i_clr_overrun = 1'b1;
        tick();
        bus.i_clr_overrun = 1'b0;
        chk("ovr_cleared", bus.o_overrun, 64'd0);
        run_to(448);
        bus.i_clr_overrun = 1'b1;   // coincides with an overrun set
        tick();
        bus.i_clr_overrun = 1'b0;
        chk("ovr_set_wins", {bus.o_valid, bus.o_overrun, bus.o_data},
            {1'b1, 1'b1, dval(448)});
        run_to(460);
        bus.i_clr_overrun = 1'b1;
        tick();
        bus.i_clr_overrun = 1'b0;
        chk("ovr_cleared2", bus.o_overrun, 64'd0);
        run_to(512);
        bus.i_ready = 1'b1;         // transfer in the capture cycle
        tick();
        bus.i_ready = 1'b0;
        chk("xfer_and_capture", {bus.o_valid, bus.o_overrun, bus.o_data},
            {1'b1, 1'b0, dval(512)});
        tick();
        chk("hold_stable", {bus.o_valid, bus.o_data}, {1'b1, dval(512)});

        // Asynchronous reset mid-frame with a pending sample
        run_to(520);
        #2;
        i_reset = 1'b0;
        #1;
        chk("async_reset",
            {bus.o_state, bus.o_pdm_clk, bus.o_sample_en, bus.o_dec_strobe,
             bus.o_valid, bus.o_overrun, bus.o_data}, 64'd0);
        bus.i_enable = 1'b0;
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            tick();
            if (bus.o_valid || bus.o_sample_en || bus.o_dec_strobe ||
                bus.o_pdm_clk || bus.o_state != 2'd0) bad = 1'b1;
        end
        chk("post_reset_quiet", bad, 64'd0);
        start_run();
        chk("reenter_warmup", {bus.o_state, bus.o_pdm_clk}, {2'd1, 1'b1});
        run_to(3);
        chk("reenter_first_sample", bus.o_sample_en, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cic_ctrl.md
CIC_CTRL -- requirements
Module: cic_ctrl

Interface
REQ-001 SHALL have parameter OW, default 19, meaning output sample width in bits.
REQ-002 SHALL have parameter R, default 16, meaning decimation factor in PDM samples per output; legal range 2..1024.
REQ-003 SHALL have parameter N, default 3, meaning CIC stage count, which is also the number of warm-up outputs discarded.
REQ-004 SHALL have parameter PDM_DIV, default 4, meaning clk cycles per PDM bit; even values only, minimum 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_enable, input, 1 bit: level request to run the decimator.
REQ-008 SHALL have port i_cic_data, input, OW bits: comb-chain output.
REQ-009 SHALL have port i_ready, input, 1 bit: downstream accepts o_data.
REQ-010 SHALL have port i_clr_overrun, input, 1 bit: clears o_overrun.
REQ-011 SHALL have port o_pdm_clk, output, 1 bit: microphone clock with 50% duty.
REQ-012 SHALL have port o_sample_en, output, 1 bit: 1-cycle integrator advance pulse.
REQ-013 SHALL have port o_dec_strobe, output, 1 bit: 1-cycle comb advance pulse.
REQ-014 SHALL have port o_data, output, OW bits: captured decimated sample.
REQ-015 SHALL have port o_valid, output, 1 bit: o_data holds an unconsumed sample.
REQ-016 SHALL have port o_overrun, output, 1 bit: sticky flag, a sample was lost.
REQ-017 SHALL have port o_state, output, 2 bits: IDLE=0, WARMUP=1, RUN=2, STOP=3.

Function
REQ-018 SHALL implement FSM states IDLE, WARMUP, RUN, STOP, all registered.
REQ-019 In IDLE, div_cnt and dec_cnt SHALL hold at 0, o_pdm_clk SHALL be low, and no pulses SHALL be issued.
REQ-020 IDLE SHALL go to WARMUP on the edge where i_enable=1; the first WARMUP cycle SHALL have div_cnt=0.
REQ-021 Outside IDLE, div_cnt SHALL count 0..PDM_DIV-1 and wrap.
REQ-022 o_pdm_clk SHALL be 1 when div_cnt<PDM_DIV/2, and 0 otherwise.
REQ-023 o_sample_en SHALL be 1 exactly in cycles where div_cnt==PDM_DIV-1.
REQ-024 dec_cnt SHALL increment on each o_sample_en and wrap from R-1 to 0.
REQ-025 o_dec_strobe SHALL be 1 exactly when o_sample_en=1 and dec_cnt==R-1.
REQ-026 Each strobe in WARMUP SHALL increment warm_cnt; on the N-th strobe, WARMUP SHALL go to RUN and that strobe's data SHALL be discarded.
REQ-027 For a strobe in RUN or STOP at cycle t, i_cic_data SHALL be captured at the end of cycle t+1, and o_valid SHALL be 1 from cycle t+2.
REQ-028 Transfer SHALL occur in any cycle with o_valid=1 and i_ready=1; o_valid SHALL clear next cycle unless a capture coincides.
REQ-029 A capture while o_valid=1 and i_ready=0 SHALL overwrite o_data, keep o_valid=1, and set o_overrun.
REQ-030 A capture coinciding with a transfer SHALL deliver the old sample, load the new one, keep o_valid=1, and not set o_overrun.
REQ-031 o_data SHALL be stable while o_valid=1 and i_ready=0, except on overwrite per REQ-029.
REQ-032 i_enable=0 in WARMUP SHALL go to IDLE immediately, with no captures.
REQ-033 i_enable=0 in RUN SHALL go to STOP.
REQ-034 STOP SHALL continue clocking until the next strobe, capture that sample, and go to IDLE on the capture edge.
REQ-035 STOP SHALL ignore i_enable; re-entry SHALL be only via IDLE, and re-entry SHALL repeat warm-up.
REQ-036 A pending o_valid/o_data SHALL persist through IDLE until transferred.
REQ-037 o_overrun SHALL clear on i_clr_overrun=1; if a set and a clear coincide, the set SHALL win.

Reset
REQ-038 i_reset=0 SHALL force, asynchronously: state=IDLE, all counters 0, o_pdm_clk=0, o_sample_en=0, o_dec_strobe=0, o_data=0, o_valid=0, o_overrun=0.
REQ-039 Reset mid-frame SHALL drop any pending sample, with no partial pulse after release.
REQ-040 After release, operation SHALL resume only via the IDLE-to-WARMUP transition.

Verification
REQ-041 Defaults, i_enable raised, i_ready=1 -> o_sample_en every 4 clks at relative cycles 3,7,...; o_dec_strobe at 63,127,191,255; first o_valid at 257; then o_valid every 64 clks.
REQ-042 i_ready=0 for 2 outputs -> first o_data retained, then overwritten; o_overrun=1 until i_clr_overrun pulse.
REQ-043 Capture in the same cycle as i_ready=1 with o_valid=1 -> new data loaded, o_valid stays 1, o_overrun=0.
REQ-044 i_enable dropped at RUN cycle 300 -> o_state=3, one more capture (strobe at 319, valid at 321), then o_state=0, o_pdm_clk=0.
REQ-045 i_enable dropped during WARMUP at cycle 100 -> immediate IDLE, no o_valid; re-enable -> full 3-output warm-up again.
REQ-046 i_reset low at RUN cycle 290 with o_valid=1 -> all outputs 0 in the same cycle; no pulses until re-enable.
